// File: rtl/shift_right_pipe.sv
// Pipelined variable right shifter: each stage conditionally shifts by 2^k, with
// arithmetic/logical fill, optional round-half-up and valid/ready bubble collapse.
module shift_right_pipe #(
  parameter int WORD_WIDTH  = 16,
  parameter int SHIFT_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WORD_WIDTH-1:0]  data_in,
  input  logic [SHIFT_WIDTH-1:0] shift_amount,
  input  logic                   arith,
  input  logic                   round_en,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WORD_WIDTH-1:0]  data_out,
  output logic [SHIFT_WIDTH:0]   in_flight
);
  localparam int CW = SHIFT_WIDTH + 1;

  logic [SHIFT_WIDTH-1:0] valid_nxt;

  for (genvar k = 0; k < SHIFT_WIDTH; k++) begin : g_stage
    localparam int SH = 1 << k;
    // Stage k only needs the shift bits it and later stages consume.
    localparam int NI = SHIFT_WIDTH - k;

    logic [WORD_WIDTH-1:0] d_in;
    logic [WORD_WIDTH-1:0] d_sh;
    logic [WORD_WIDTH-1:0] data_q;
    logic [NI-1:0]         s_in;
    logic                  a_in;
    logic                  r_in;
    logic                  g_in;
    logic                  v_in;
    logic                  g_sh;
    logic                  fill;
    logic                  rdy;
    logic                  valid_q;
    logic                  rnd_q;
    logic                  guard_q;

    if (k == 0) begin : g_src
      assign d_in = data_in;
      assign s_in = shift_amount;
      assign a_in = arith;
      assign r_in = round_en;
      assign g_in = 1'b0;
      assign v_in = in_valid;
    end else begin : g_src
      assign d_in = g_stage[k-1].data_q;
      assign s_in = g_stage[k-1].g_fwd.rem_q;
      assign a_in = g_stage[k-1].g_fwd.arith_q;
      assign r_in = g_stage[k-1].rnd_q;
      assign g_in = g_stage[k-1].guard_q;
      assign v_in = g_stage[k-1].valid_q;
    end

    if (k == SHIFT_WIDTH - 1) begin : g_rdy
      assign rdy = !valid_q || out_ready;
    end else begin : g_rdy
      assign rdy = !valid_q || g_stage[k+1].rdy;
    end

    assign fill = a_in & d_in[WORD_WIDTH-1];

    if (SH >= WORD_WIDTH) begin : g_shift
      assign d_sh = {WORD_WIDTH{fill}};
      assign g_sh = fill;
    end else begin : g_shift
      assign d_sh = {{SH{fill}}, d_in[WORD_WIDTH-1:SH]};
      assign g_sh = d_in[SH-1];
    end

    assign valid_nxt[k] = rdy ? v_in : valid_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= 1'b0;
        data_q  <= '0;
        rnd_q   <= 1'b0;
        guard_q <= 1'b0;
      end else if (rdy) begin
        valid_q <= v_in;
        data_q  <= s_in[0] ? d_sh : d_in;
        rnd_q   <= r_in;
        guard_q <= s_in[0] ? g_sh : g_in;
      end
    end

    if (k < SHIFT_WIDTH - 1) begin : g_fwd
      logic [NI-2:0] rem_q;
      logic          arith_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rem_q   <= '0;
          arith_q <= 1'b0;
        end else if (rdy) begin
          rem_q   <= s_in[NI-1:1];
          arith_q <= a_in;
        end
      end
    end
  end

  // Counting next-state valids keeps in_flight aligned with the stage registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) in_flight <= '0;
    else     in_flight <= CW'($countones(valid_nxt));
  end

  assign in_ready  = g_stage[0].rdy;
  assign out_valid = g_stage[SHIFT_WIDTH-1].valid_q;
  assign data_out  = g_stage[SHIFT_WIDTH-1].data_q
                   + WORD_WIDTH'(g_stage[SHIFT_WIDTH-1].rnd_q & g_stage[SHIFT_WIDTH-1].guard_q);

endmodule
